// File: rtl/iob_split_tmo_pkg.sv
// Shared interconnect header: native-bus request/response field layout and the split FSM encoding.
// Field positions are generic in ADDR_W/DATA_W; valid is the request MSB and ready is the response LSB.
package iob_split_tmo_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Request = {valid, address, wdata, wstrb}
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int req_wstrb_lsb();
    return 0;
  endfunction

  function automatic int req_wdata_lsb(input int dw);
    return dw / 8;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw / 8 + dw;
  endfunction

  function automatic int req_valid_bit(input int aw, input int dw);
    return dw / 8 + dw + aw;
  endfunction

  // Response = {rdata, ready}
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int resp_ready_bit();
    return 0;
  endfunction

  function automatic int resp_rdata_lsb();
    return 1;
  endfunction

endpackage

// File: rtl/iob_split_tmo_cnt.sv
// Clearable, enabled, saturating timeout counter; hit is combinational on count == TIMEOUT-1.
// TIMEOUT=0 ties hit low and removes the counter entirely.
module iob_split_tmo_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign hit = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] r_cnt;

      // Saturates at TIMEOUT so a stuck enable can never wrap back onto the hit value.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          r_cnt <= '0;
        end else if (en && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign hit = (r_cnt == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/iob_split_tmo.sv
// 1:N native-bus split on an address field with per-transaction routing lock and stall timeout abort.
// Zero added latency on the normal path; timeout/decode errors answer from a one-cycle ERR state.
module iob_split_tmo
  import iob_split_tmo_pkg::*;
#(
  parameter int          N_SLAVES = 2,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          P_SEL    = ADDR_W - 1,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]              m_req,
  output logic [resp_w(DATA_W)-1:0]                     m_resp,
  output logic [N_SLAVES*req_w(ADDR_W, DATA_W)-1:0]     s_req,
  input  logic [N_SLAVES*resp_w(DATA_W)-1:0]            s_resp,
  output logic                                          err,
  output logic [ADDR_W-1:0]                             err_addr
);

  localparam int REQ_W    = req_w(ADDR_W, DATA_W);
  localparam int RESP_W   = resp_w(DATA_W);
  localparam int RQ_VLD   = req_valid_bit(ADDR_W, DATA_W);
  localparam int RQ_ADDR  = req_addr_lsb(DATA_W);
  localparam int RS_RDY   = resp_ready_bit();
  localparam int RS_DAT   = resp_rdata_lsb();
  localparam int SEL_W    = $clog2(N_SLAVES);
  localparam logic [DATA_W-1:0] ERR_D = DATA_W'(ERR_DATA);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [SEL_W-1:0]    r_sel_q;
  logic [SEL_W-1:0]    w_sel;
  logic [SEL_W-1:0]    w_route;
  logic [ADDR_W-1:0]   r_err_addr;
  logic                w_m_valid;
  logic [ADDR_W-1:0]   w_m_addr;
  logic                w_dec_ok;
  logic                w_routing;
  logic                w_s_rdy;
  logic [DATA_W-1:0]   w_s_rdata;
  logic [N_SLAVES-1:0] w_s_valid;
  logic                w_m_ready;
  logic [DATA_W-1:0]   w_m_rdata;
  logic                w_hit;

  assign w_m_valid = m_req[RQ_VLD];
  assign w_m_addr  = m_req[RQ_ADDR +: ADDR_W];
  assign w_sel     = w_m_addr[P_SEL -: SEL_W];
  assign w_dec_ok  = (int'(w_sel) < N_SLAVES);
  // Once BUSY the latched select owns the route; later address wobble cannot redirect it.
  assign w_route   = (r_state == ST_BUSY) ? r_sel_q : w_sel;
  assign w_routing = ((r_state == ST_IDLE) && w_dec_ok) || (r_state == ST_BUSY);

  always_comb begin
    w_s_rdy   = 1'b0;
    w_s_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (int'(w_route) == i) begin
        w_s_rdy   = s_resp[i*RESP_W + RS_RDY];
        w_s_rdata = s_resp[i*RESP_W + RS_DAT +: DATA_W];
      end
    end
  end

  iob_split_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (r_state == ST_IDLE),
    .en  (r_state == ST_BUSY),
    .hit (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ready wins over a coincident timeout hit.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_m_valid) begin
          if (!w_dec_ok)     w_next = ST_ERR;
          else if (!w_s_rdy) w_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_m_valid && w_s_rdy) w_next = ST_IDLE;
        else if (w_hit)           w_next = ST_ERR;
      end
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_q    <= '0;
      r_err_addr <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (w_next == ST_BUSY)) r_sel_q <= w_sel;
      if ((r_state != ST_ERR) && (w_next == ST_ERR))   r_err_addr <= w_m_addr;
    end
  end

  always_comb begin
    w_s_valid = '0;
    w_m_ready = 1'b0;
    w_m_rdata = w_s_rdata;
    if (!rst) begin
      if (r_state == ST_ERR) begin
        w_m_ready = 1'b1;
        w_m_rdata = ERR_D;
      end else if (w_routing && w_m_valid) begin
        w_m_ready = w_s_rdy;
        for (int i = 0; i < N_SLAVES; i++) begin
          if (int'(w_route) == i) w_s_valid[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_req = {N_SLAVES{1'b0, m_req[REQ_W-2:0]}};
    for (int i = 0; i < N_SLAVES; i++) begin
      s_req[i*REQ_W + RQ_VLD] = w_s_valid[i];
    end
  end

  assign m_resp   = {w_m_rdata, w_m_ready};
  assign err      = !rst && (r_state == ST_ERR);
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_iob_split_tmo.sv
// Directed bench for iob_split_tmo: 3 slaves, select field addr[31:30], TIMEOUT=8.
// Inputs change and outputs are sampled around the falling edge, clear of the rising edge.
module tb_iob_split_tmo;

  localparam int N      = 3;
  localparam int TMO    = 8;
  localparam int REQ_W  = 1 + 32 + 32 + 4;
  localparam int RESP_W = 33;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mv;
  logic [31:0]           maddr;
  logic [31:0]           mwdata;
  logic [3:0]            mwstrb;
  logic [REQ_W-1:0]      m_req;
  logic [RESP_W-1:0]     m_resp;
  logic [N*REQ_W-1:0]    s_req;
  logic [N*RESP_W-1:0]   s_resp;
  logic                  err;
  logic [31:0]           err_addr;
  logic [N-1:0]          s_rdy;
  logic [31:0]           s_dat [N];
  logic [N-1:0]          s_vld;
  logic                  m_ready;
  logic [31:0]           m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign m_req   = {mv, maddr, mwdata, mwstrb};
  assign m_ready = m_resp[0];
  assign m_rdata = m_resp[32:1];

  for (genvar g = 0; g < N; g++) begin : g_slv
    assign s_resp[g*RESP_W +: RESP_W] = {s_dat[g], s_rdy[g]};
    assign s_vld[g] = s_req[g*REQ_W + REQ_W - 1];
  end

  iob_split_tmo #(
    .N_SLAVES (N),
    .ADDR_W   (32),
    .DATA_W   (32),
    .P_SEL    (31),
    .TIMEOUT  (TMO),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_resp   (m_resp),
    .s_req    (s_req),
    .s_resp   (s_resp),
    .err      (err),
    .err_addr (err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mv = 1'b1; maddr = 32'h4000_0010; mwdata = '0; mwstrb = '0;
    s_rdy = 3'b010;
    for (int i = 0; i < N; i++) s_dat[i] = '0;

    // Reset: slave valid and master ready held low even with a live request.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_svld",  s_vld,    3'b000);
    chk("rst_mrdy",  m_ready,  1'b0);
    chk("rst_err",   err,      1'b0);
    chk("rst_eaddr", err_addr, 32'h0);
    @(negedge clk); rst = 1'b0; mv = 1'b0; s_rdy = '0;
    #1; chk("idle_mrdy", m_ready, 1'b0);

    // Normal routing to slave 1, ready three cycles later.
    @(negedge clk); mv = 1'b1; maddr = 32'h4000_0010;
    #1;
    chk("t1_svld0", s_vld, 3'b010);
    chk("t1_rdy0",  m_ready, 1'b0);
    chk("t1_addr",  s_req[36 +: 32], 32'h4000_0010);
    @(negedge clk); #1; chk("t1_svld1", s_vld, 3'b010);
    @(negedge clk); maddr = 32'h8000_0000;
    #1; chk("t1_lock", s_vld, 3'b010);
    @(negedge clk); maddr = 32'h4000_0010; s_rdy[1] = 1'b1; s_dat[1] = 32'h1234_5678;
    #1;
    chk("t1_rdy",   m_ready, 1'b1);
    chk("t1_rdata", m_rdata, 32'h1234_5678);
    chk("t1_err",   err, 1'b0);
    @(negedge clk); mv = 1'b0; s_rdy = '0;
    #1;
    chk("t1_svld_end", s_vld, 3'b000);
    chk("t1_err_end",  err, 1'b0);

    // Back-to-back writes to a combinational-ready slave 0.
    s_rdy[0] = 1'b1; s_dat[0] = 32'hA5A5_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mv = 1'b1; maddr = 32'(4*k); mwdata = 32'(k + 16); mwstrb = 4'hF;
      #1;
      chk("t2_rdy",   m_ready, 1'b1);
      chk("t2_svld",  s_vld, 3'b001);
      chk("t2_wstrb", s_req[2*REQ_W +: 4], 4'hF);
      chk("t2_wdata", s_req[4 +: 32], 32'(k + 16));
    end
    @(negedge clk); s_rdy = '0; maddr = 32'h4000_0000; mwstrb = '0;
    #1; chk("t2_idle", s_vld, 3'b010);
    @(negedge clk); s_rdy[1] = 1'b1; s_dat[1] = 32'hBEEF_0001;
    #1;
    chk("t2_rdy1",   m_ready, 1'b1);
    chk("t2_rdata1", m_rdata, 32'hBEEF_0001);
    @(negedge clk); mv = 1'b0; s_rdy = '0;

    // Timeout on slave 2: abort response 9 cycles after the request.
    @(negedge clk); mv = 1'b1; maddr = 32'h8000_0000; s_dat[2] = 32'h0BAD_0BAD;
    #1;
    chk("t3_svld0", s_vld, 3'b100);
    chk("t3_rdy0",  m_ready, 1'b0);
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk); #1;
      chk("t3_wait_rdy",  m_ready, 1'b0);
      chk("t3_wait_svld", s_vld, 3'b100);
    end
    chk("t3_eaddr_pre", err_addr, 32'h0);
    @(negedge clk); #1;
    chk("t3_rdy",   m_ready, 1'b1);
    chk("t3_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("t3_err",   err, 1'b1);
    chk("t3_eaddr", err_addr, 32'h8000_0000);
    chk("t3_svld",  s_vld, 3'b000);
    @(negedge clk); mv = 1'b0; s_rdy[2] = 1'b1;
    #1;
    chk("t3_err_end", err, 1'b0);
    chk("t3_late",    m_ready, 1'b0);
    @(negedge clk); s_rdy = '0;

    // Ready arrives on the same cycle the counter hits.
    @(negedge clk); mv = 1'b1; maddr = 32'h8000_0004; s_dat[2] = 32'h55AA_55AA;
    repeat (TMO - 1) @(negedge clk);
    @(negedge clk); s_rdy[2] = 1'b1;
    #1;
    chk("t4_rdy",   m_ready, 1'b1);
    chk("t4_rdata", m_rdata, 32'h55AA_55AA);
    chk("t4_err",   err, 1'b0);
    @(negedge clk); mv = 1'b0; s_rdy = '0;
    #1;
    chk("t4_err_end", err, 1'b0);
    chk("t4_eaddr",   err_addr, 32'h8000_0000);
    chk("t4_rdy_end", m_ready, 1'b0);

    // Decode error: select 3 with only 3 slaves.
    @(negedge clk); mv = 1'b1; maddr = 32'hC000_0000;
    #1;
    chk("t5_svld", s_vld, 3'b000);
    chk("t5_rdy0", m_ready, 1'b0);
    chk("t5_err0", err, 1'b0);
    @(negedge clk); #1;
    chk("t5_rdy",   m_ready, 1'b1);
    chk("t5_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("t5_err",   err, 1'b1);
    chk("t5_eaddr", err_addr, 32'hC000_0000);
    chk("t5_svld1", s_vld, 3'b000);
    @(negedge clk); mv = 1'b0;
    #1; chk("t5_err_end", err, 1'b0);

    // Reset while BUSY drops the transaction without an error pulse.
    @(negedge clk); mv = 1'b1; maddr = 32'h4000_0020;
    @(negedge clk); #1; chk("t6_busy", s_vld, 3'b010);
    @(negedge clk); rst = 1'b1; s_rdy[1] = 1'b1;
    #1;
    chk("t6_rst_svld", s_vld, 3'b000);
    chk("t6_rst_rdy",  m_ready, 1'b0);
    chk("t6_rst_err",  err, 1'b0);
    @(negedge clk); rst = 1'b0; mv = 1'b0; s_rdy = '0;
    #1;
    chk("t6_post_err",   err, 1'b0);
    chk("t6_post_eaddr", err_addr, 32'h0);
    @(negedge clk); mv = 1'b1; maddr = 32'h0000_0100; s_rdy[0] = 1'b1; s_dat[0] = 32'hCAFE_F00D;
    #1;
    chk("t6_svld",  s_vld, 3'b001);
    chk("t6_rdy",   m_ready, 1'b1);
    chk("t6_rdata", m_rdata, 32'hCAFE_F00D);
    @(negedge clk); mv = 1'b0; s_rdy = '0;
    #1; chk("t6_err_end", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
